// File: rtl/int_arb_pkg.sv
// Shared types and helpers for the interrupt claim/complete arbiter.
package int_arb_pkg;

  localparam int unsigned MAX_SRC  = 32;
  localparam int unsigned MAX_ID_W = $clog2(MAX_SRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } src_state_e;

  // Round-robin pointer advance: one past id, wrapping at n-1 -> 0.
  function automatic logic [MAX_ID_W-1:0] rr_next(input logic [MAX_ID_W-1:0] id,
                                                  input int unsigned n);
    if (32'(id) + 32'd1 >= n) return '0;
    return id + MAX_ID_W'(1);
  endfunction

endpackage

// File: rtl/int_gateway.sv
// Per-source pending/claimed lifecycle with a registered, enable-masked request.
// INT_ARB_EDGE_EN selects rising-edge triggering with a 1-deep remembered edge.
module int_gateway
  import int_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_sync_i,
  input  logic       enable_i,
  input  logic       claim_i,
  input  logic       complete_i,
  output src_state_e state_o,
  output logic       req_o
);

  src_state_e state_q;
  logic       req_q;
  logic       trig;

`ifdef INT_ARB_EDGE_EN
  logic in_q;
  logic mem_q;
  logic rise;

  assign rise = in_sync_i & ~in_q;
  assign trig = rise | mem_q;

  // An edge seen outside IDLE is held until the source returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q  <= 1'b0;
      mem_q <= 1'b0;
    end else begin
      in_q <= in_sync_i;
      if (state_q == IDLE) mem_q <= 1'b0;
      else if (rise)       mem_q <= 1'b1;
    end
  end
`else
  assign trig = in_sync_i;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= PENDING;
            req_q   <= enable_i;
          end else begin
            req_q <= 1'b0;
          end
        end
        PENDING: begin
          if (claim_i) begin
            state_q <= CLAIMED;
            req_q   <= 1'b0;
          end else begin
            req_q <= enable_i;
          end
        end
        CLAIMED: begin
          req_q <= 1'b0;
          if (complete_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign req_o   = req_q;

endmodule

// File: rtl/int_claim_arbiter.sv
// Interrupt gateway bank with round-robin claim/complete arbitration.
// Define INT_ARB_EDGE_EN for edge-triggered sources (default: level).
module int_claim_arbiter
  import int_arb_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] in_sync,
  input  logic [N_SRC-1:0] enable,
  output logic             sel_valid,
  output logic [ID_W-1:0]  sel_id,
  input  logic             claim,
  input  logic             complete,
  input  logic [ID_W-1:0]  complete_id,
  output logic             err
);

  src_state_e       st [N_SRC];
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] claim_vec;
  logic [N_SRC-1:0] cmp_vec;
  logic             claim_ok;
  logic             cmp_ok;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  sel_id_q, sel_id_d;
  logic             sel_valid_q, sel_valid_d;
  logic             err_q, err_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_gateway u_gw (
      .clock      (clock),
      .reset      (reset),
      .in_sync_i  (in_sync[g]),
      .enable_i   (enable[g]),
      .claim_i    (claim_vec[g]),
      .complete_i (cmp_vec[g]),
      .state_o    (st[g]),
      .req_o      (req[g])
    );
  end

  assign claim_ok = claim & sel_valid_q;
  assign cmp_ok   = |cmp_vec;

  // Per-source claim/complete strobes; completes only land on CLAIMED sources.
  always_comb begin
    claim_vec = '0;
    cmp_vec   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      claim_vec[i] = claim_ok && (sel_id_q == ID_W'(i));
      cmp_vec[i]   = complete && (complete_id == ID_W'(i)) && (st[i] == CLAIMED);
    end
  end

  // First requesting source at or after rr, wrapping past N_SRC-1.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!win_found && req[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // A claim blanks the selection for one cycle so it cannot be taken twice.
  always_comb begin
    sel_valid_d = 1'b0;
    sel_id_d    = '0;
    rr_d        = rr_q;
    if (claim_ok) begin
      rr_d = ID_W'(rr_next(MAX_ID_W'(sel_id_q), N_SRC));
    end else if (win_found) begin
      sel_valid_d = 1'b1;
      sel_id_d    = win_id;
    end
    err_d = (claim & ~sel_valid_q) | (complete & ~cmp_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q        <= '0;
      sel_valid_q <= 1'b0;
      sel_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      sel_valid_q <= sel_valid_d;
      sel_id_q    <= sel_id_d;
      err_q       <= err_d;
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_id    = sel_id_q;
  assign err       = err_q;

endmodule
